// File: rtl/hangman_pkg.sv
// Shared constants and state types for the hangman round controller.
package hangman_pkg;

  localparam int unsigned KEY_W     = 5;
  localparam int unsigned LETTERS   = 26;
  localparam int unsigned IDX_OUT_W = 8;
  localparam int unsigned CNT_W     = 4;

  localparam logic [KEY_W-1:0] KEY_START      = 5'd26;
  localparam logic [KEY_W-1:0] KEY_MAX_LETTER = 5'd25;

  // Handler state encodings as reported on game_state.
  typedef enum logic [1:0] {
    GS_START    = 2'd0,
    GS_INGAME   = 2'd1,
    GS_WINGAME  = 2'd2,
    GS_LOSTGAME = 2'd3
  } game_state_e;

  // Round sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ARM,
    ST_WAIT_START,
    ST_WAIT_GUESS,
    ST_ISSUE,
    ST_SETTLE,
    ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/hangman_round_ctrl_if.sv
// Keyboard/handler-facing signal bundle of the round controller.
interface hangman_round_ctrl_if;
  import hangman_pkg::*;

  logic                 key_valid;
  logic [KEY_W-1:0]     key_code;
  logic                 key_ready;
  logic [1:0]           game_state;
  logic                 load;
  logic [KEY_W-1:0]     load_x;
  logic [LETTERS-1:0]   mask;
  logic [IDX_OUT_W-1:0] word_idx;
  logic                 dup_guess;
  logic                 round_over;
  logic [7:0]           wins;
  logic [7:0]           losses;

  // Surrounding system: keyboard decoder plus game handler.
  modport master (
    output key_valid, key_code, game_state,
    input  key_ready, load, load_x, mask, word_idx, dup_guess, round_over, wins, losses
  );

  // Round controller.
  modport slave (
    input  key_valid, key_code, game_state,
    output key_ready, load, load_x, mask, word_idx, dup_guess, round_over, wins, losses
  );

endinterface

// File: rtl/hangman_word_rom.sv
// Combinational word-mask table; the 16 base words repeat for larger tables.
module hangman_word_rom
  import hangman_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [LETTERS-1:0] mask
);

  localparam logic [LETTERS-1:0] WORDS [16] = '{
    26'h00030C1,  // HANGMAN
    26'h0008811,  // APPLE
    26'h0002003,  // BANANA
    26'h000401C,  // CODE
    26'h0004944,  // LOGIC
    26'h2020013,  // ZEBRA
    26'h2110100,  // QUIZ
    26'h2000201,  // JAZZ
    26'h0600011,  // WAVE
    26'h0804020,  // FOX
    26'h1000410,  // KEY
    26'h0004C04,  // CLOCK
    26'h00A1110,  // TIMER
    26'h0046904,  // SILICON
    26'h0224950,  // VERILOG
    26'h2108810   // PUZZLE
  };

  logic [3:0] base;

  assign base = 4'(idx);
  assign mask = WORDS[base];

endmodule

// File: rtl/hangman_round_ctrl.sv
// Round sequencer between the keyboard letter decoder and the game handler.
module hangman_round_ctrl
  import hangman_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  hangman_round_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  ctrl_state_e          state_q, state_d;
  logic [7:0]           lfsr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LETTERS-1:0]   tried_q, tried_d;
  logic [IDX_OUT_W-1:0] word_idx_q, word_idx_d;
  logic [LETTERS-1:0]   mask_q, mask_d;
  logic                 load_q, load_d;
  logic [KEY_W-1:0]     load_x_q, load_x_d;
  logic                 dup_q, dup_d;
  logic                 round_over_q;
  logic [7:0]           wins_q, wins_d;
  logic [7:0]           losses_q, losses_d;
  logic [IDX_W-1:0]     sel_idx;
  logic [LETTERS-1:0]   rom_mask;
  logic                 accept;

  assign sel_idx = lfsr_q[IDX_W-1:0];

  hangman_word_rom #(.IDX_W(IDX_W)) u_rom (
    .idx  (sel_idx),
    .mask (rom_mask)
  );

  assign bus.key_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_GUESS) || (state_q == ST_DONE);
  assign accept        = bus.key_valid && bus.key_ready;

  // Free-running word-select LFSR, taps 8,6,5,4.
  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tried_d    = tried_q;
    word_idx_d = word_idx_q;
    mask_d     = mask_q;
    load_d     = 1'b0;
    load_x_d   = load_x_q;
    dup_d      = 1'b0;
    wins_d     = wins_q;
    losses_d   = losses_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && bus.key_code == KEY_START) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        word_idx_d = IDX_OUT_W'(sel_idx);
        mask_d     = rom_mask;
        tried_d    = '0;
        load_d     = 1'b1;
        load_x_d   = KEY_START;
        state_d    = ST_ARM;
      end
      ST_ARM: begin
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (bus.game_state == GS_INGAME) begin
          state_d = ST_WAIT_GUESS;
        end else if (cnt_q == 4'd15) begin
          mask_d  = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WAIT_GUESS: begin
        // A handler reset wins over any key offered in the same cycle.
        if (bus.game_state == GS_START) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          if (bus.key_code == KEY_START) begin
            state_d = ST_SELECT;
          end else if (bus.key_code <= KEY_MAX_LETTER) begin
            if (tried_q[bus.key_code]) begin
              dup_d = 1'b1;
            end else begin
              tried_d[bus.key_code] = 1'b1;
              load_d   = 1'b1;
              load_x_d = bus.key_code;
              state_d  = ST_ISSUE;
            end
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d = '0;
          case (bus.game_state)
            GS_WINGAME: begin
              if (wins_q != 8'hFF) wins_d = wins_q + 8'd1;
              state_d = ST_DONE;
            end
            GS_LOSTGAME: begin
              if (losses_q != 8'hFF) losses_d = losses_q + 8'd1;
              state_d = ST_DONE;
            end
            GS_INGAME: state_d = ST_WAIT_GUESS;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_DONE: begin
        if (accept && bus.key_code == KEY_START) state_d = ST_SELECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      tried_q      <= '0;
      word_idx_q   <= '0;
      mask_q       <= '0;
      load_q       <= 1'b0;
      load_x_q     <= '0;
      dup_q        <= 1'b0;
      round_over_q <= 1'b0;
      wins_q       <= '0;
      losses_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      tried_q      <= tried_d;
      word_idx_q   <= word_idx_d;
      mask_q       <= mask_d;
      load_q       <= load_d;
      load_x_q     <= load_x_d;
      dup_q        <= dup_d;
      round_over_q <= (state_d == ST_DONE);
      wins_q       <= wins_d;
      losses_q     <= losses_d;
    end
  end

  assign bus.load       = load_q;
  assign bus.load_x     = load_x_q;
  assign bus.mask       = mask_q;
  assign bus.word_idx   = word_idx_q;
  assign bus.dup_guess  = dup_q;
  assign bus.round_over = round_over_q;
  assign bus.wins       = wins_q;
  assign bus.losses     = losses_q;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Randomized self-checking bench for hangman_round_ctrl with a round-level reference model.
module tb_hangman_round_ctrl;
  import hangman_pkg::*;

  localparam int unsigned S = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  hangman_round_ctrl_if bus ();

  hangman_round_ctrl #(
    .NUM_WORDS     (16),
    .SETTLE_CYCLES (S),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  // Clock edges since the last edge that saw reset asserted.
  always @(posedge clk) edges <= reset ? edges + 1 : 0;

  string words [16] = '{"HANGMAN", "APPLE", "BANANA", "CODE", "LOGIC", "ZEBRA",
                        "QUIZ", "JAZZ", "WAVE", "FOX", "KEY", "CLOCK",
                        "TIMER", "SILICON", "VERILOG", "PUZZLE"};

  bit tried_m [26];
  int wins_m   = 0;
  int losses_m = 0;

  function automatic logic [25:0] mask_of(input string s);
    logic [25:0] m = '0;
    for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 65] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [4:0] code, output bit rdy);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    rdy = bus.key_ready;
    tick();
    bus.key_valid = 1'b0;
  endtask

  // Key 26 from IDLE/WAIT_GUESS/DONE through to WAIT_GUESS.
  task automatic start_round(input int wait_cyc);
    bit rdy;
    int widx;
    send_key(5'd26, rdy);
    check("start_rdy", 32'(rdy), 1);
    bus.game_state = 2'd0;
    widx = int'(lfsr_at(edges)) % 16;
    check("select_load", 32'(bus.load), 0);
    tick();
    check("arm_load", 32'(bus.load), 1);
    check("arm_load_x", 32'(bus.load_x), 26);
    check("arm_word_idx", 32'(bus.word_idx), 32'(widx));
    check("arm_mask", 32'(bus.mask), 32'(mask_of(words[widx])));
    check("arm_rdy", 32'(bus.key_ready), 0);
    for (int i = 0; i < 26; i++) tried_m[i] = 1'b0;
    tick();
    check("wstart_load", 32'(bus.load), 0);
    for (int i = 0; i < wait_cyc; i++) begin
      check("wstart_rdy", 32'(bus.key_ready), 0);
      tick();
    end
    bus.game_state = 2'd1;
    tick();
    check("wguess_rdy", 32'(bus.key_ready), 1);
    check("wguess_over", 32'(bus.round_over), 0);
  endtask

  // One key offered in WAIT_GUESS; res is what the stub handler reports after a new letter.
  task automatic guess(input logic [4:0] code, input logic [1:0] res);
    bit rdy;
    send_key(code, rdy);
    check("guess_rdy", 32'(rdy), 1);
    if (code > 5'd25) begin
      check("drop_load", 32'(bus.load), 0);
      check("drop_dup", 32'(bus.dup_guess), 0);
      check("drop_rdy", 32'(bus.key_ready), 1);
      return;
    end
    if (tried_m[code]) begin
      check("dup_pulse", 32'(bus.dup_guess), 1);
      check("dup_load", 32'(bus.load), 0);
      tick();
      check("dup_clear", 32'(bus.dup_guess), 0);
      check("dup_load2", 32'(bus.load), 0);
      check("dup_rdy", 32'(bus.key_ready), 1);
      return;
    end
    tried_m[code] = 1'b1;
    check("issue_load", 32'(bus.load), 1);
    check("issue_load_x", 32'(bus.load_x), 32'(code));
    check("issue_dup", 32'(bus.dup_guess), 0);
    check("issue_rdy", 32'(bus.key_ready), 0);
    bus.game_state = res;
    for (int i = 0; i < int'(S); i++) begin
      tick();
      check("settle_rdy", 32'(bus.key_ready), 0);
      check("settle_load", 32'(bus.load), 0);
      check("settle_load_x", 32'(bus.load_x), 32'(code));
    end
    tick();
    if (res == 2'd2) wins_m   = (wins_m   < 255) ? wins_m + 1   : 255;
    if (res == 2'd3) losses_m = (losses_m < 255) ? losses_m + 1 : 255;
    check("result_rdy", 32'(bus.key_ready), 1);
    check("result_over", 32'(bus.round_over), (res >= 2'd2) ? 1 : 0);
    check("result_wins", 32'(bus.wins), 32'(wins_m));
    check("result_losses", 32'(bus.losses), 32'(losses_m));
  endtask

  // A non-start key offered in IDLE or DONE must have no effect.
  task automatic idle_drop(input logic [4:0] code, input bit in_done);
    bit rdy;
    send_key(code, rdy);
    check("idle_drop_rdy", 32'(rdy), 1);
    check("idle_drop_load", 32'(bus.load), 0);
    check("idle_drop_dup", 32'(bus.dup_guess), 0);
    check("idle_drop_over", 32'(bus.round_over), 32'(in_done));
    check("idle_drop_rdy2", 32'(bus.key_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rdy;
    int phase;  // 0 idle, 1 guessing, 2 round over
    bus.key_valid  = 1'b0;
    bus.key_code   = '0;
    bus.game_state = 2'd0;
    repeat (3) tick();

    check("rst_load", 32'(bus.load), 0);
    check("rst_load_x", 32'(bus.load_x), 0);
    check("rst_mask", 32'(bus.mask), 0);
    check("rst_word_idx", 32'(bus.word_idx), 0);
    check("rst_dup", 32'(bus.dup_guess), 0);
    check("rst_wins", 32'(bus.wins), 0);
    check("rst_losses", 32'(bus.losses), 0);
    check("rst_over", 32'(bus.round_over), 0);
    check("rst_rdy", 32'(bus.key_ready), 1);
    reset = 1'b1;

    // Directed: drops, start, guess, duplicate, win, loss.
    idle_drop(5'd7, 1'b0);
    start_round(2);
    guess(5'd7, 2'd1);
    guess(5'd7, 2'd1);
    guess(5'd30, 2'd1);
    guess(5'd2, 2'd2);
    idle_drop(5'd5, 1'b1);
    start_round(3);
    guess(5'd9, 2'd3);
    start_round(0);

    // Handler reset in the same cycle as a letter: key discarded, back to IDLE.
    bus.game_state = 2'd0;
    send_key(5'd4, rdy);
    check("prio_rdy", 32'(rdy), 1);
    check("prio_load", 32'(bus.load), 0);
    check("prio_dup", 32'(bus.dup_guess), 0);
    bus.game_state = 2'd1;
    idle_drop(5'd4, 1'b0);

    // Handler never reaches INGAME: give up after 16 cycles.
    send_key(5'd26, rdy);
    bus.game_state = 2'd0;
    repeat (17) tick();
    check("tmo_rdy_before", 32'(bus.key_ready), 0);
    tick();
    check("tmo_rdy_after", 32'(bus.key_ready), 1);
    check("tmo_mask", 32'(bus.mask), 0);
    check("tmo_load", 32'(bus.load), 0);

    // Randomized rounds.
    phase = 0;
    for (int r = 0; r < 40; r++) begin
      start_round(int'($urandom_range(0, 4)));
      phase = 1;
      for (int g = 0; g < 12 && phase == 1; g++) begin
        int p;
        logic [4:0] code;
        logic [1:0] res;
        bit was_new;
        p = int'($urandom_range(0, 99));
        if (p < 5) begin
          start_round(int'($urandom_range(0, 2)));
          continue;
        end
        code = (p < 15) ? 5'($urandom_range(27, 31)) : 5'($urandom_range(0, 9));
        p = int'($urandom_range(0, 99));
        res = (p < 8) ? 2'd2 : (p < 16) ? 2'd3 : (p < 20) ? 2'd0 : 2'd1;
        was_new = (code <= 5'd25) && !tried_m[code];
        guess(code, res);
        if (was_new && res != 2'd1) phase = (res == 2'd0) ? 0 : 2;
      end
      if (phase != 1) idle_drop(5'($urandom_range(0, 25)), phase == 2);
    end

    // Win tally saturates at 255.
    while (wins_m < 255) begin
      start_round(0);
      guess(5'd0, 2'd2);
    end
    start_round(0);
    guess(5'd1, 2'd2);
    check("wins_saturated", 32'(bus.wins), 255);

    // Reset during SETTLE, then a clean restart.
    start_round(1);
    send_key(5'd7, rdy);
    bus.game_state = 2'd1;
    tick();
    reset = 1'b0;
    tick();
    wins_m   = 0;
    losses_m = 0;
    check("midrst_load", 32'(bus.load), 0);
    check("midrst_load_x", 32'(bus.load_x), 0);
    check("midrst_mask", 32'(bus.mask), 0);
    check("midrst_word_idx", 32'(bus.word_idx), 0);
    check("midrst_wins", 32'(bus.wins), 0);
    check("midrst_losses", 32'(bus.losses), 0);
    check("midrst_over", 32'(bus.round_over), 0);
    check("midrst_rdy", 32'(bus.key_ready), 1);
    reset = 1'b1;
    tick();
    check("postrst_load", 32'(bus.load), 0);
    start_round(1);
    guess(5'd3, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
